sensor_monitor: RTL and testbench
=================================

SENSOR_MONITOR -- requirements
Module: sensor_monitor

Interface
REQ-001 Parameter NUM_SENSORS, default 4, sensor channel count; legal range 3 to 16.
REQ-002 Parameter PERSIST, default 3, consecutive faulted samples required to raise an alarm; legal range 1 to 255.
REQ-003 Parameter CNT_W, default 8, width of the alarm event counter.
REQ-004 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port n_rst, input, 1 bit, reset; synchronous, active-low.
REQ-006 Port enable, input, 1 bit, high to allow fault qualification.
REQ-007 Port sensors, input, NUM_SENSORS bits, raw sensor flags; 1 means the sensor reports a problem.
REQ-008 Port mask, input, NUM_SENSORS bits; 1 means ignore that channel.
REQ-009 Port clear, input, 1 bit, alarm acknowledge; level-sampled every cycle.
REQ-010 Port error, output, 1 bit, latched alarm.
REQ-011 Port pending, output, 1 bit, fault is present but not yet qualified.
REQ-012 Port snapshot, output, NUM_SENSORS bits, masked sensor vector captured at alarm entry.
REQ-013 Port event_count, output, CNT_W bits, number of alarm entries.

Function
REQ-014 masked SHALL equal sensors AND NOT mask, evaluated combinationally each cycle.
REQ-015 fault SHALL be: masked[0] OR (masked[1] AND any of masked[NUM_SENSORS-1:2]).
REQ-016 The FSM SHALL have exactly three states: IDLE, PENDING and ALARM.
REQ-017 A persistence counter SHALL count consecutive edges where fault and enable are both high; it SHALL clear to 0 on any edge where either is low.
REQ-018 From IDLE: on fault and enable, go to PENDING with counter = 1; if PERSIST = 1, go directly to ALARM instead.
REQ-019 From PENDING: on fault and enable with counter+1 = PERSIST, go to ALARM.
    - On fault and enable with counter+1 below PERSIST, stay in PENDING and increment the counter.
    - If fault is low or enable is low, go to IDLE.
REQ-020 Timing: if fault and enable are high at edges k through k+PERSIST-1, error SHALL be high immediately after edge k+PERSIST-1.
REQ-021 ALARM SHALL be held regardless of fault, enable or mask changes until a clear is accepted.
REQ-022 From ALARM: if clear = 1 and fault = 0 at an edge, go to IDLE.
    - If clear = 1 while fault = 1, ignore the clear and stay in ALARM.
    - A later clear with fault = 0 is required to leave ALARM.
REQ-023 clear SHALL have no effect in IDLE or PENDING.
REQ-024 On the edge entering ALARM, snapshot SHALL load masked as sampled at that edge and hold it until the next ALARM entry.
REQ-025 On the edge entering ALARM, event_count SHALL increment, saturating at all-ones; it SHALL never wrap.
REQ-026 error SHALL equal (state == ALARM) and pending SHALL equal (state == PENDING); both are driven directly from state registers with no combinational path from inputs.
REQ-027 Re-qualification after a clear SHALL restart from counter = 0; no count carries over.

Reset
REQ-028 When n_rst = 0 at a rising edge, the block SHALL set: state = IDLE, persistence counter = 0, error = 0, pending = 0, snapshot = 0, event_count = 0.
REQ-029 Reset SHALL take priority over all other inputs, including in the middle of PENDING or ALARM.
REQ-030 Outputs SHALL be undefined until the first clock edge with n_rst = 0.

Structure
REQ-031 Shared package sensor_pkg SHALL hold:
    - the state enum typedef (IDLE, PENDING, ALARM);
    - default constants for NUM_SENSORS, PERSIST and CNT_W.
REQ-032 The persistence counter SHALL be one sub-module, persist_counter.
    - Parameter: width.
    - Inputs: count_enable, clear and rollover value.
    - Output: rollover flag.
REQ-033 The total design SHALL be one FSM, one saturating event counter and the snapshot register.

Verification (NUM_SENSORS = 4, PERSIST = 3, mask = 0 unless noted)
REQ-034 Drive sensors = 4'b0001 with enable = 1 for 3 edges:
    - pending = 1 after edges 1 and 2;
    - error = 1 after edge 3;
    - snapshot = 4'b0001, event_count = 1.
REQ-035 Drive sensors = 4'b0110 for 2 edges, then 4'b0000:
    - pending returns to 0;
    - error stays 0 and event_count stays 0.
REQ-036 Raise an alarm with 4'b1010, hold the fault, and pulse clear:
    - error stays 1;
    - drop sensors to 0 and pulse clear: error = 0 on the next edge.
REQ-037 Drive mask = 4'b0001 and sensors = 4'b0001 for 5 edges:
    - error and pending stay 0;
    - then sensors = 4'b0100 alone: no alarm, because bit1 is not set.
REQ-038 Assert n_rst = 0 for 1 edge while in ALARM with event_count = 5:
    - all outputs go to 0 after that edge.
REQ-039 With CNT_W = 2, run 5 alarm/clear cycles:
    - event_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and defaults for the sensor monitor: FSM state encoding, parameter defaults
// and the channel fault predicate.
package sensor_pkg;

    localparam int unsigned NumSensorsDefault = 4;
    localparam int unsigned PersistDefault    = 3;
    localparam int unsigned CntWDefault       = 8;
    localparam int unsigned PersistW          = 8;
    localparam int unsigned MaxSensors        = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StAlarm   = 2'd2
    } state_e;

    // Unused upper channels must be zero so they cannot contribute to the fault term.
    function automatic logic fault_of(input logic [MaxSensors-1:0] m);
        return m[0] | (m[1] & (|m[MaxSensors-1:2]));
    endfunction

endpackage

// File: rtl/persist_counter.sv
// Consecutive-sample counter; flags when the next counted sample reaches the rollover value.
module persist_counter #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             count_enable,
    input  logic             clear,
    input  logic [width-1:0] rollover_value,
    output logic             rollover
);

    logic [width-1:0] count_q, count_d;
    logic [width:0]   count_next;

    assign count_next = {1'b0, count_q} + {{width{1'b0}}, 1'b1};
    assign rollover   = count_enable & (count_next == {1'b0, rollover_value});

    // Saturate rather than wrap so a long-held fault never looks like a fresh run.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable && (count_q != '1)) begin
            count_d = count_next[width-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sensor_monitor.sv
// Sensor fault monitor: qualifies a persistent fault into a latched alarm, records the masked
// sensor vector at alarm entry and counts alarm entries with saturation.
module sensor_monitor
    import sensor_pkg::*;
#(
    parameter int unsigned NUM_SENSORS = NumSensorsDefault,
    parameter int unsigned PERSIST     = PersistDefault,
    parameter int unsigned CNT_W       = CntWDefault
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic [NUM_SENSORS-1:0] mask,
    input  logic                   clear,
    output logic                   error,
    output logic                   pending,
    output logic [NUM_SENSORS-1:0] snapshot,
    output logic [CNT_W-1:0]       event_count
);

    logic [NUM_SENSORS-1:0] masked;
    logic [MaxSensors-1:0]  masked_ext;
    logic                   fault;
    logic                   qualify;
    logic                   persist_clear;
    logic                   rollover;
    logic                   enter_alarm;

    state_e                 state_q, state_d;
    logic                   error_q, pending_q;
    logic [NUM_SENSORS-1:0] snapshot_q;
    logic [CNT_W-1:0]       event_count_q;

    always_comb begin
        masked                       = sensors & ~mask;
        masked_ext                   = '0;
        masked_ext[NUM_SENSORS-1:0]  = masked;
    end

    assign fault         = fault_of(masked_ext);
    assign qualify       = fault & enable;
    assign persist_clear = ~qualify;

    persist_counter #(
        .width(PersistW)
    ) u_persist_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .count_enable  (qualify),
        .clear         (persist_clear),
        .rollover_value(PersistW'(PERSIST)),
        .rollover      (rollover)
    );

    // Counter is zero in idle, so rollover from idle means PERSIST == 1.
    assign enter_alarm = qualify & rollover & (state_q != StAlarm);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StPending: begin
                if (enter_alarm) begin
                    state_d = StAlarm;
                end else if (qualify) begin
                    state_d = StPending;
                end else begin
                    state_d = StIdle;
                end
            end
            StAlarm: begin
                // Acknowledge is only accepted once the fault itself has gone away.
                if (clear && !fault) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            error_q       <= 1'b0;
            pending_q     <= 1'b0;
            snapshot_q    <= '0;
            event_count_q <= '0;
        end else begin
            state_q   <= state_d;
            error_q   <= (state_d == StAlarm);
            pending_q <= (state_d == StPending);
            if (enter_alarm) begin
                snapshot_q <= masked;
                if (event_count_q != '1) begin
                    event_count_q <= event_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign error       = error_q;
    assign pending     = pending_q;
    assign snapshot    = snapshot_q;
    assign event_count = event_count_q;

endmodule

// File: tb/tb_sensor_monitor.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares after
// every rising edge. A second instance with a 2-bit counter exercises event saturation.
module tb_sensor_monitor;

    localparam int P = 3;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sensors = 4'd0;
    logic [3:0] mask = 4'd0;

    logic       error_a, pending_a, error_b, pending_b;
    logic [3:0] snapshot_a, snapshot_b;
    logic [7:0] event_count_a;
    logic [1:0] event_count_b;

    sensor_monitor #(.NUM_SENSORS(4), .PERSIST(P), .CNT_W(8)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .enable(enable), .sensors(sensors), .mask(mask),
        .clear(clear), .error(error_a), .pending(pending_a), .snapshot(snapshot_a),
        .event_count(event_count_a)
    );

    sensor_monitor #(.NUM_SENSORS(4), .PERSIST(P), .CNT_W(2)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .enable(enable), .sensors(sensors), .mask(mask),
        .clear(clear), .error(error_b), .pending(pending_b), .snapshot(snapshot_b),
        .event_count(event_count_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       error;
        logic       pending;
        logic [3:0] snapshot;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_pop;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: length of the current qualified run, alarm latch, records.
    int         run = 0;
    bit         alarm = 1'b0;
    logic [3:0] m_snap = 4'd0;
    int         m_cnt = 0;
    int         m_cnt2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [3:0] s, input logic [3:0] mk,
                        input logic clr);
        logic [3:0] mv;
        bit         f;
        exp_t       e;
        @(negedge clk);
        n_rst   = r;
        enable  = en;
        sensors = s;
        mask    = mk;
        clear   = clr;
        mv = s & ~mk;
        f  = mv[0] || (mv[1] && (mv[2] || mv[3]));
        if (!r) begin
            run = 0; alarm = 1'b0; m_snap = 4'd0; m_cnt = 0; m_cnt2 = 0;
        end else if (alarm) begin
            if (clr && !f) alarm = 1'b0;
        end else if (en && f) begin
            run++;
            if (run >= P) begin
                alarm  = 1'b1;
                run    = 0;
                m_snap = mv;
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
        end else begin
            run = 0;
        end
        e.error    = alarm;
        e.pending  = !alarm && (run > 0);
        e.snapshot = m_snap;
        e.cnt      = 8'(m_cnt);
        e.cnt2     = 2'(m_cnt2);
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e_pop = exp_q.pop_front();
                chk("error_a",    32'(error_a),       32'(e_pop.error));
                chk("pending_a",  32'(pending_a),     32'(e_pop.pending));
                chk("snapshot_a", 32'(snapshot_a),    32'(e_pop.snapshot));
                chk("count_a",    32'(event_count_a), 32'(e_pop.cnt));
                chk("error_b",    32'(error_b),       32'(e_pop.error));
                chk("pending_b",  32'(pending_b),     32'(e_pop.pending));
                chk("snapshot_b", 32'(snapshot_b),    32'(e_pop.snapshot));
                chk("count_b",    32'(event_count_b), 32'(e_pop.cnt2));
            end
        end
    end

    initial begin
        step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1);
        // Basic qualification, then acknowledge with fault gone.
        repeat (3) step(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
        // Short fault run that must not alarm.
        repeat (2) step(1'b1, 1'b1, 4'b0110, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
        // Enable gap breaks the run.
        repeat (2) step(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
        repeat (2) step(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
        // Clear ignored while fault persists, accepted once it drops.
        repeat (3) step(1'b1, 1'b1, 4'b1010, 4'b0000, 1'b0);
        repeat (2) step(1'b1, 1'b1, 4'b1010, 4'b0000, 1'b1);
        step(1'b1, 1'b0, 4'b1010, 4'b1111, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
        // Masked channel and bit2 alone never fault.
        repeat (5) step(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0);
        repeat (4) step(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0);
        // Count from zero: five alarm entries, saturating the 2-bit counter, then reset in alarm.
        step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            repeat (3) step(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
            if (i < 4) step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
        end
        step(1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 200) != 0, ($urandom % 8) != 0, 4'($urandom),
                 (($urandom % 4) == 0) ? 4'($urandom) : 4'd0, ($urandom % 4) == 0);
        end
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
